// File: rtl/flash_arb_pkg.sv
// Shared types and defaults for the flash bus arbiter.
// Build option: FLASH_ARB_WDOG_EN enables the user-tenure watchdog.
package flash_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PFL_OWN  = 3'd1,
    USR_OWN  = 3'd2,
    TURN     = 3'd3,
    USR_LOCK = 3'd4
  } arb_state_t;

  typedef enum logic {
    PFL = 1'b0,
    USR = 1'b1
  } owner_t;

  localparam int          TURN_CYC_DEF = 4;
  localparam logic [23:0] HOLD_MAX_DEF = 24'hFFFFFF;

endpackage

// File: rtl/flash_arb_wdog.sv
// User-tenure hold counter with a one-cycle expiry strobe.
// Only instantiated when FLASH_ARB_WDOG_EN is defined.
module flash_arb_wdog
  import flash_arb_pkg::*;
#(
  parameter logic [23:0] HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_expire
);

  logic [23:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 24'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  // r_cnt holds (tenure cycle - 1), so this fires on the last allowed cycle
  assign o_expire = i_run && (r_cnt == HOLD_MAX - 24'd1);

endmodule

// File: rtl/flash_bus_arbiter.sv
// Two-master flash bus arbiter (PFL vs user controller) with turnaround.
// Build option: FLASH_ARB_WDOG_EN limits user tenure to HOLD_MAX cycles.
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int          TURN_CYC = TURN_CYC_DEF,
  parameter logic [23:0] HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic       clkin_max_100,
  input  logic       sys_resetn,
  input  logic       pfl_req,
  input  logic       usr_req,
  output logic       pfl_gnt,
  output logic       usr_gnt,
  output logic       bus_sel,
  output logic       bus_hiz,
  output logic       wdog_err,
  output logic [2:0] arb_state
);

  arb_state_t r_state;
  owner_t     r_last;
  logic       r_fresh;
  logic       r_lock;
  logic [3:0] r_turn_cnt;
  logic       r_pfl_gnt;
  logic       r_usr_gnt;
  logic       r_bus_sel;
  logic       r_bus_hiz;
  logic       r_wdog_err;
  logic       w_expire;
  logic       w_pfl_wins;
  logic       w_locked;

`ifdef FLASH_ARB_WDOG_EN
  flash_arb_wdog #(
    .HOLD_MAX (HOLD_MAX)
  ) u_wdog (
    .clk      (clkin_max_100),
    .rst_n    (sys_resetn),
    .i_run    (r_state == USR_OWN),
    .o_expire (w_expire)
  );
`else
  // HOLD_MAX only matters to the watchdog build
  assign w_expire = 1'b0 && (HOLD_MAX != 24'd0);
`endif

  // On a tie the previous owner yields; the very first tie goes to PFL
  assign w_pfl_wins = r_fresh || (r_last == USR);
  assign w_locked   = (r_state == USR_LOCK);

  always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state    <= IDLE;
      r_last     <= PFL;
      r_fresh    <= 1'b1;
      r_lock     <= 1'b0;
      r_turn_cnt <= '0;
      r_pfl_gnt  <= 1'b0;
      r_usr_gnt  <= 1'b0;
      r_bus_sel  <= 1'b1;
      r_bus_hiz  <= 1'b1;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_err <= 1'b0;
      case (r_state)
        IDLE, USR_LOCK: begin
          if (w_locked && !usr_req) begin
            r_lock <= 1'b0;
          end
          if (pfl_req &&
              (w_locked || !usr_req || w_pfl_wins)) begin
            r_state   <= PFL_OWN;
            r_pfl_gnt <= 1'b1;
            r_bus_sel <= 1'b1;
            r_bus_hiz <= 1'b0;
            r_last    <= PFL;
            r_fresh   <= 1'b0;
          end else if (usr_req && !w_locked) begin
            r_state   <= USR_OWN;
            r_usr_gnt <= 1'b1;
            r_bus_sel <= 1'b0;
            r_bus_hiz <= 1'b0;
            r_last    <= USR;
            r_fresh   <= 1'b0;
          end else if (w_locked && !usr_req) begin
            r_state <= IDLE;
          end
        end
        PFL_OWN: begin
          if (!pfl_req) begin
            r_state    <= TURN;
            r_pfl_gnt  <= 1'b0;
            r_bus_hiz  <= 1'b1;
            r_turn_cnt <= 4'(TURN_CYC - 1);
          end
        end
        USR_OWN: begin
          if (!usr_req || w_expire) begin
            r_state    <= TURN;
            r_usr_gnt  <= 1'b0;
            r_bus_hiz  <= 1'b1;
            r_turn_cnt <= 4'(TURN_CYC - 1);
            r_wdog_err <= usr_req;
            r_lock     <= usr_req;
          end
        end
        TURN: begin
          if (r_turn_cnt == 4'd0) begin
            r_state <= r_lock ? USR_LOCK : IDLE;
          end else begin
            r_turn_cnt <= r_turn_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pfl_gnt <= 1'b0;
          r_usr_gnt <= 1'b0;
          r_bus_hiz <= 1'b1;
        end
      endcase
    end
  end

  assign pfl_gnt   = r_pfl_gnt;
  assign usr_gnt   = r_usr_gnt;
  assign bus_sel   = r_bus_sel;
  assign bus_hiz   = r_bus_hiz;
  assign wdog_err  = r_wdog_err;
  assign arb_state = r_state;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Randomized bench for flash_bus_arbiter with a tenure-level reference model.
// Define FLASH_ARB_WDOG_EN to also exercise the watchdog (HOLD_MAX=16).
module tb_flash_bus_arbiter;

  localparam int          TC = 4;
  localparam logic [23:0] HM = 24'd16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pfl_req = 1'b0;
  logic       usr_req = 1'b0;
  logic       pfl_gnt;
  logic       usr_gnt;
  logic       bus_sel;
  logic       bus_hiz;
  logic       wdog_err;
  logic [2:0] arb_state;

  always #5 clk = ~clk;

  flash_bus_arbiter #(
    .TURN_CYC (TC),
    .HOLD_MAX (HM)
  ) dut (
    .clkin_max_100 (clk),
    .sys_resetn    (rst_n),
    .pfl_req       (pfl_req),
    .usr_req       (usr_req),
    .pfl_gnt       (pfl_gnt),
    .usr_gnt       (usr_gnt),
    .bus_sel       (bus_sel),
    .bus_hiz       (bus_hiz),
    .wdog_err      (wdog_err),
    .arb_state     (arb_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: who holds the bus (0 none, 1 PFL, 2 user), turnaround cycles left,
  // tenure length so far, last owner, and the post-watchdog user lockout.
  int m_owner;
  int m_turn;
  int m_hold;
  int m_last;
  bit m_fresh;
  bit m_sel;
  bit m_lock;
  bit m_err;
  bit p_sel = 1'b1;
  bit p_hiz = 1'b1;

  function automatic void m_reset();
    m_owner = 0;
    m_turn  = 0;
    m_hold  = 0;
    m_last  = 1;
    m_fresh = 1'b1;
    m_sel   = 1'b1;
    m_lock  = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic int m_state();
    if (m_owner != 0) return m_owner;
    if (m_turn > 0) return 3;
    if (m_lock) return 4;
    return 0;
  endfunction

  function automatic void m_step(input bit p, input bit u);
    bit rq;
    int w;
    m_err = 1'b0;
    w = 0;
    if (m_owner != 0) begin
      rq = (m_owner == 1) ? p : u;
      if (!rq) begin
        m_owner = 0;
        m_turn  = TC;
      end
`ifdef FLASH_ARB_WDOG_EN
      else if (m_owner == 2 && m_hold == int'(HM)) begin
        m_owner = 0;
        m_turn  = TC;
        m_err   = 1'b1;
        m_lock  = 1'b1;
      end
`endif
      else begin
        m_hold++;
      end
    end else if (m_turn > 0) begin
      m_turn--;
    end else begin
      if (m_lock) begin
        if (!u) m_lock = 1'b0;
        if (p) w = 1;
      end else if (p && u) begin
        w = (m_fresh || m_last == 2) ? 1 : 2;
      end else if (p) begin
        w = 1;
      end else if (u) begin
        w = 2;
      end
      if (w != 0) begin
        m_owner = w;
        m_last  = w;
        m_fresh = 1'b0;
        m_sel   = (w == 1);
        m_hold  = 1;
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("pfl_gnt", int'(pfl_gnt), int'(m_owner == 1));
    chk("usr_gnt", int'(usr_gnt), int'(m_owner == 2));
    chk("bus_sel", int'(bus_sel), int'(m_sel));
    chk("bus_hiz", int'(bus_hiz), int'(m_owner == 0));
    chk("wdog_err", int'(wdog_err), int'(m_err));
    chk("arb_state", int'(arb_state), m_state());
    chk("gnt_overlap", int'(pfl_gnt & usr_gnt), 0);
    if (bus_sel != p_sel) chk("sel_toggle_live", int'(p_hiz | bus_hiz), 1);
    p_sel = bus_sel;
    p_hiz = bus_hiz;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) m_step(pfl_req, usr_req);
    #1 compare();
  endtask

  task automatic async_rst(input bit p, input bit u);
    #2 rst_n = 1'b0;
    pfl_req = p;
    usr_req = u;
    #1 m_reset();
    compare();
    chk("rst_pfl_gnt", int'(pfl_gnt), 0);
    chk("rst_usr_gnt", int'(usr_gnt), 0);
    chk("rst_bus_hiz", int'(bus_hiz), 1);
    chk("rst_bus_sel", int'(bus_sel), 1);
    chk("rst_state", int'(arb_state), 0);
    cycle();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input bit want_usr, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while ((want_usr ? !usr_gnt : !pfl_gnt) && n < 40);
  endtask

  initial begin
    int n;
    m_reset();
    repeat (2) cycle();
    chk("init_state", int'(arb_state), 0);
    chk("init_hiz", int'(bus_hiz), 1);
    chk("init_sel", int'(bus_sel), 1);
    @(negedge clk) rst_n = 1'b1;

    // Single PFL tenure and exact turnaround length
    pfl_req = 1'b1;
    cycle();
    chk("pfl_grant", int'(pfl_gnt), 1);
    chk("pfl_sel", int'(bus_sel), 1);
    chk("pfl_hiz", int'(bus_hiz), 0);
    repeat (14) cycle();
    pfl_req = 1'b0;
    cycle();
    chk("pfl_drop", int'(pfl_gnt), 0);
    chk("pfl_drop_hiz", int'(bus_hiz), 1);
    chk("turn_enter", int'(arb_state), 3);
    repeat (3) cycle();
    chk("turn_last", int'(arb_state), 3);
    cycle();
    chk("turn_done", int'(arb_state), 0);

    // Both requesting out of reset: PFL first, user after TURN_CYC+2
    async_rst(1'b1, 1'b1);
    cycle();
    chk("tie_after_rst", int'(pfl_gnt), 1);
    repeat (5) cycle();
    pfl_req = 1'b0;
    wait_gnt(1'b1, n);
    chk("usr_latency", n, 6);

    // PFL request during user tenure waits
    pfl_req = 1'b1;
    repeat (8) cycle();
    chk("no_preempt_usr", int'(usr_gnt), 1);
    usr_req = 1'b0;
    wait_gnt(1'b0, n);
    chk("pfl_latency", n, 6);

    // User request during PFL tenure waits
    usr_req = 1'b1;
    repeat (5) cycle();
    chk("no_preempt_pfl", int'(pfl_gnt), 1);
    pfl_req = 1'b0;
    wait_gnt(1'b1, n);
    chk("usr_latency2", n, 6);

    // Tie after a user tenure goes to PFL
    usr_req = 1'b0;
    cycle();
    pfl_req = 1'b1;
    usr_req = 1'b1;
    wait_gnt(1'b0, n);
    chk("tie_after_usr", int'(pfl_gnt), 1);

    // Async reset in the middle of a user tenure
    pfl_req = 1'b0;
    wait_gnt(1'b1, n);
    repeat (3) cycle();
    async_rst(1'b0, 1'b0);
    repeat (5) cycle();
    chk("idle_after_rst", int'(usr_gnt | pfl_gnt), 0);
    usr_req = 1'b1;
    cycle();
    chk("usr_after_rst", int'(usr_gnt), 1);

`ifdef FLASH_ARB_WDOG_EN
    repeat (15) cycle();
    chk("wd_last_cycle", int'(usr_gnt), 1);
    cycle();
    chk("wd_pulse", int'(wdog_err), 1);
    chk("wd_drop", int'(usr_gnt), 0);
    cycle();
    chk("wd_one_shot", int'(wdog_err), 0);
    repeat (2) cycle();
    cycle();
    chk("wd_lock", int'(arb_state), 4);
    repeat (5) cycle();
    chk("wd_lock_hold", int'(arb_state), 4);
    usr_req = 1'b0;
    cycle();
    chk("wd_unlock", int'(arb_state), 0);
`endif

    usr_req = 1'b0;
    repeat (8) cycle();

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) pfl_req = ~pfl_req;
      if ($urandom_range(0, 7) == 0) usr_req = ~usr_req;
      if ($urandom_range(0, 2999) == 0) begin
        async_rst(pfl_req, usr_req);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
